// File: rtl/fp_mul_round_pack.sv
// fp_mul_round_pack
//   Back end of the single-precision multiplier. Takes the raw significand
//   product plus operand exponents and result sign, normalises it, rounds to
//   nearest-even, saturates to infinity / flushes to zero and packs an
//   IEEE-754 single. Two registered stages with valid/ready flow control.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream bundle handshake
//   in_sign             result sign (A.sign ^ B.sign)
//   in_zero             either operand is zero
//   in_exp_a/in_exp_b   biased operand exponents
//   in_mant_prod        {1,fracA} * {1,fracB}, 2*(MAN_W+1) bits
//   out_valid/out_ready downstream result handshake
//   out_result          packed single-precision result
//   out_overflow        result saturated to infinity
//   out_underflow       result flushed to zero
//   out_inexact         rounding discarded nonzero bits
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Output stage accepts when it is empty or its result is being taken;
// the input stage advances whenever the output stage accepts. in_ready is the
// only combinational path (from out_ready); every other output is a register.

module fp_mul_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic                   in_zero,
    input  logic [EXP_W-1:0]       in_exp_a,
    input  logic [EXP_W-1:0]       in_exp_b,
    input  logic [2*(MAN_W+1)-1:0] in_mant_prod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_inexact
);

    localparam int PROD_W = 2 * (MAN_W + 1);
    // Two extra bits: one for the sum headroom, one for the sign.
    localparam int E_W    = EXP_W + 2;
    localparam logic signed [E_W-1:0] BIAS_E  = E_W'(BIAS);
    localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ONE   = E_W'(1);

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_accept;

    assign s2_accept = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_accept;

    // ---------------- stage 1: normalise ----------------
    logic                  s1_sign_q, s1_sign_d;
    logic                  s1_zero_q, s1_zero_d;
    logic signed [E_W-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0]      s1_mant_q, s1_mant_d;
    logic                  s1_guard_q, s1_guard_d;
    logic                  s1_sticky_q, s1_sticky_d;

    logic signed [E_W-1:0] n_exp;
    logic [MAN_W-1:0]      n_mant;
    logic                  n_guard;
    logic                  n_sticky;

    always_comb begin
        n_exp = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - BIAS_E;
        // Product of two [1,2) significands lies in [1,4): the top bit says
        // whether it needs a one-place right shift.
        if (in_mant_prod[PROD_W-1]) begin
            n_mant   = in_mant_prod[PROD_W-2 -: MAN_W];
            n_guard  = in_mant_prod[PROD_W-2-MAN_W];
            n_sticky = |in_mant_prod[PROD_W-3-MAN_W:0];
            n_exp    = n_exp + E_ONE;
        end else begin
            n_mant   = in_mant_prod[PROD_W-3 -: MAN_W];
            n_guard  = in_mant_prod[PROD_W-3-MAN_W];
            n_sticky = |in_mant_prod[PROD_W-4-MAN_W:0];
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d   = in_sign;
                s1_zero_d   = in_zero;
                s1_exp_d    = n_exp;
                s1_mant_d   = n_mant;
                s1_guard_d  = n_guard;
                s1_sticky_d = n_sticky;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [31:0] out_result_q, out_result_d;
    logic        out_overflow_q, out_overflow_d;
    logic        out_underflow_q, out_underflow_d;
    logic        out_inexact_q, out_inexact_d;

    logic                  round_up;
    logic [MAN_W:0]        mant_sum;
    logic signed [E_W-1:0] e_r;
    logic [31:0]           res;
    logic                  res_ovf;
    logic                  res_unf;
    logic                  res_inx;

    always_comb begin
        round_up = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
        // A carry out of the fraction leaves it all zeros, which is exactly
        // the renormalised value; only the exponent needs the bump.
        mant_sum = {1'b0, s1_mant_q} + (MAN_W+1)'(round_up);
        e_r      = s1_exp_q + $signed({{(E_W-1){1'b0}}, mant_sum[MAN_W]});
        res_inx  = s1_guard_q || s1_sticky_q;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res      = 32'({s1_sign_q, e_r[EXP_W-1:0], mant_sum[MAN_W-1:0]});
        if (s1_zero_q) begin
            res     = 32'h0000_0000;
            res_inx = 1'b0;
        end else if (e_r >= EXP_MAX) begin
            res     = 32'({s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}});
            res_ovf = 1'b1;
            res_inx = 1'b1;
        end else if (e_r < E_ONE) begin
            res     = 32'({s1_sign_q, {(EXP_W+MAN_W){1'b0}}});
            res_unf = 1'b1;
            res_inx = 1'b1;
        end
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_overflow_d  = out_overflow_q;
        out_underflow_d = out_underflow_q;
        out_inexact_d   = out_inexact_q;
        if (s2_accept) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d    = res;
                out_overflow_d  = res_ovf;
                out_underflow_d = res_unf;
                out_inexact_d   = res_inx;
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_zero_q       <= 1'b0;
            s1_exp_q        <= '0;
            s1_mant_q       <= '0;
            s1_guard_q      <= 1'b0;
            s1_sticky_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_inexact_q   <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_sign_q       <= s1_sign_d;
            s1_zero_q       <= s1_zero_d;
            s1_exp_q        <= s1_exp_d;
            s1_mant_q       <= s1_mant_d;
            s1_guard_q      <= s1_guard_d;
            s1_sticky_q     <= s1_sticky_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_overflow_q  <= out_overflow_d;
            out_underflow_q <= out_underflow_d;
            out_inexact_q   <= out_inexact_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_overflow_q;
    assign out_underflow = out_underflow_q;
    assign out_inexact   = out_inexact_q;

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Bench for fp_mul_round_pack: hand-computed vector table run through a
// scoreboard (full-rate and random-backpressure passes), plus directed
// sequences for latency, stall stability and mid-flight reset.

module tb_fp_mul_round_pack;

    typedef struct {
        logic        sign;
        logic        zero;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [47:0] prod;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic        in_zero;
    logic [7:0]  in_exp_a;
    logic [7:0]  in_exp_b;
    logic [47:0] in_mant_prod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    always #5 clk = ~clk;

    fp_mul_round_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_zero      (in_zero),
        .in_exp_a     (in_exp_a),
        .in_exp_b     (in_exp_b),
        .in_mant_prod (in_mant_prod),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_inexact  (out_inexact)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [34:0] exp_q[$];
    vec_t vecs[$];
    logic rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic vec_t mk(input logic s, input logic z, input logic [7:0] a,
                                input logic [7:0] b, input logic [47:0] p,
                                input logic [31:0] r, input logic o, input logic u,
                                input logic x);
        vec_t v;
        v.sign = s; v.zero = z; v.ea = a; v.eb = b; v.prod = p;
        v.res = r; v.ovf = o; v.unf = u; v.inx = x;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                note_timeout("unexpected_output");
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                check("sb_result", {29'b0, out_result, out_overflow, out_underflow, out_inexact},
                      {29'b0, e});
            end
        end
    end

    // Random backpressure, changed just after the active edge.
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put_inputs(input vec_t v);
        in_sign      = v.sign;
        in_zero      = v.zero;
        in_exp_a     = v.ea;
        in_exp_b     = v.eb;
        in_mant_prod = v.prod;
        in_valid     = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v);
        int budget;
        budget = 0;
        put_inputs(v);
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) note_timeout("send_ready");
        else exp_q.push_back({v.res, v.ovf, v.unf, v.inx});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        #1;
        if (exp_q.size() != 0) note_timeout(name);
        else check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Output must be absent one edge after acceptance and present after the next.
    task automatic latency_test(input vec_t v, input string tag);
        put_inputs(v);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        exp_q.push_back({v.res, v.ovf, v.unf, v.inx});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_cycle1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_cycle2_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_cycle2_result"}, 64'(out_result), 64'(v.res));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] held;
        int budget;

        vecs.push_back(mk(0, 0, 127, 127, 48'h9000_0000_0000, 32'h4010_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 127, 127, 48'h4000_00C0_0000, 32'h3F80_0002, 0, 0, 1));
        vecs.push_back(mk(0, 0, 127, 127, 48'h4000_0040_0000, 32'h3F80_0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 127, 127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 0, 0, 1));
        vecs.push_back(mk(1, 0, 200, 200, 48'h8000_0000_0000, 32'hFF80_0000, 1, 0, 1));
        vecs.push_back(mk(0, 0,  10,  10, 48'h4000_0000_0000, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 1, 127, 127, 48'h9000_0000_0000, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 127, 127, 48'h4000_0040_0001, 32'h3F80_0001, 0, 0, 1));
        vecs.push_back(mk(0, 0, 127, 127, 48'h4000_0020_0000, 32'h3F80_0000, 0, 0, 1));
        vecs.push_back(mk(1, 0,   1, 126, 48'h4000_0000_0000, 32'h8000_0000, 0, 1, 1));
        vecs.push_back(mk(0, 0,   1, 127, 48'h4000_0000_0000, 32'h0080_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 127, 254, 48'h4000_0000_0000, 32'h7F00_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 127, 254, 48'h8000_0000_0000, 32'h7F80_0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 127, 254, 48'h7FFF_FFC0_0000, 32'h7F80_0000, 1, 0, 1));
        vecs.push_back(mk(1, 0, 127, 127, 48'h9000_0000_0000, 32'hC010_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 127, 127, 48'h8000_0080_0000, 32'h4000_0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 127, 127, 48'h8000_0180_0000, 32'h4000_0002, 0, 0, 1));
        vecs.push_back(mk(1, 1, 200, 200, 48'h8000_0000_0000, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 126, 48'h7FFF_FFC0_0000, 32'h0080_0000, 0, 0, 1));

        // reset state
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_sign = 1'b0; in_zero = 1'b0; in_exp_a = '0; in_exp_b = '0; in_mant_prod = '0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // latency with the 1.5*1.5 case
        latency_test(vecs[0], "lat");

        // full-rate table pass
        foreach (vecs[i]) send(vecs[i]);
        drain("drain_full_rate");

        // random backpressure table pass
        rand_ready_en = 1'b1;
        foreach (vecs[i]) send(vecs[i]);
        drain("drain_random");
        rand_ready_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // four back-to-back bundles with a 5-cycle stall after the first result
        fork
            begin
                for (int i = 0; i < 4; i++) send(vecs[i + 1]);
            end
            begin
                budget = 0;
                @(posedge clk); #1;
                while (!out_valid && budget < 20) begin
                    @(posedge clk); #1;
                    budget++;
                end
                if (!out_valid) begin
                    note_timeout("stall_first_valid");
                end else begin
                    out_ready = 1'b0;
                    held = out_result;
                    for (int c = 0; c < 5; c++) begin
                        @(posedge clk); #1;
                        check("stall_out_valid", 64'(out_valid), 64'd1);
                        check("stall_result_stable", 64'(out_result), 64'(held));
                        check("stall_in_ready", 64'(in_ready), 64'd0);
                    end
                    out_ready = 1'b1;
                end
            end
        join
        drain("drain_stall");

        // reset with two bundles in flight
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[3]);
        check("inflight_out_valid", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_result", 64'(out_result), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_reset_idle", 64'(out_valid), 64'd0);
        end
        latency_test(vecs[1], "post_reset_lat");
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
